ps2_cmd_decoder: RTL and testbench



---
 rtl/uno_key_pkg.sv | 58 +++++
 rtl/key_repeat_timer.sv | 39 +++
 rtl/ps2_cmd_decoder.sv | 129 ++++++++++++
 tb/tb_ps2_cmd_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uno_key_pkg.sv
// Scan-code constants, command indices and prefix-state type shared by the
// PS/2 command decoder and its helpers.
package uno_key_pkg;

    localparam int NUM_CMDS = 5;

    localparam logic [7:0] SC_BREAK      = 8'hF0;
    localparam logic [7:0] SC_EXT        = 8'hE0;
    localparam logic [7:0] SC_LEFT       = 8'h15;
    localparam logic [7:0] SC_RIGHT      = 8'h24;
    localparam logic [7:0] SC_SELECT     = 8'h5A;
    localparam logic [7:0] SC_START      = 8'h29;
    localparam logic [7:0] SC_UNO        = 8'h3C;
    localparam logic [7:0] SC_EXT_LEFT   = 8'h6B;
    localparam logic [7:0] SC_EXT_RIGHT  = 8'h74;
    localparam logic [7:0] SC_EXT_SELECT = 8'h5A;

    typedef enum logic [2:0] {
        CMD_LEFT   = 3'd0,
        CMD_RIGHT  = 3'd1,
        CMD_SELECT = 3'd2,
        CMD_START  = 3'd3,
        CMD_UNO    = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXT_BRK
    } pfx_state_e;

    // One-hot command for a scan code; zero when the code is not mapped.
    function automatic logic [NUM_CMDS-1:0] key_onehot(input logic [7:0] code,
                                                       input logic       ext);
        logic [NUM_CMDS-1:0] oh;
        oh = '0;
        if (ext) begin
            case (code)
                SC_EXT_LEFT:   oh[CMD_LEFT]   = 1'b1;
                SC_EXT_RIGHT:  oh[CMD_RIGHT]  = 1'b1;
                SC_EXT_SELECT: oh[CMD_SELECT] = 1'b1;
                default:       oh = '0;
            endcase
        end else begin
            case (code)
                SC_LEFT:   oh[CMD_LEFT]   = 1'b1;
                SC_RIGHT:  oh[CMD_RIGHT]  = 1'b1;
                SC_SELECT: oh[CMD_SELECT] = 1'b1;
                SC_START:  oh[CMD_START]  = 1'b1;
                SC_UNO:    oh[CMD_UNO]    = 1'b1;
                default:   oh = '0;
            endcase
        end
        return oh;
    endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Auto-repeat timer: first fire DELAY cycles after start, then every PERIOD
// cycles until cancelled. Start or cancel in the same cycle suppresses a fire.
module key_repeat_timer #(
    parameter int DELAY  = 500000,
    parameter int PERIOD = 150000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_cancel,
    output logic o_fire
);

    localparam int MAXC = (DELAY > PERIOD) ? DELAY : PERIOD;
    localparam int CW   = $clog2(MAXC + 1);

    logic          r_active;
    logic [CW-1:0] r_cnt;
    logic          w_zero;

    assign w_zero = (r_cnt == '0);
    assign o_fire = r_active && w_zero && !i_start && !i_cancel;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= CW'(DELAY - 1);
        end else if (i_cancel) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (r_active) begin
            r_cnt <= w_zero ? CW'(PERIOD - 1) : r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/ps2_cmd_decoder.sv
// PS/2 scan-code stream to one-shot game commands with held-state tracking.
// Optional auto-repeat of left/right is enabled by defining KEY_AUTOREPEAT_EN.
module ps2_cmd_decoder
    import uno_key_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 4095,
    parameter int REPEAT_DELAY   = 500000,
    parameter int REPEAT_PERIOD  = 150000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scan_valid,
    input  logic [7:0] i_scan_code,
    output logic       o_left,
    output logic       o_right,
    output logic       o_select,
    output logic       o_start,
    output logic       o_uno,
    output logic [4:0] o_held
);

    localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

    pfx_state_e          r_state;
    logic [TW-1:0]       r_tmo;
    logic [NUM_CMDS-1:0] r_held;
    logic [NUM_CMDS-1:0] r_pulse;

    logic                w_ext;
    logic                w_brk_ev;
    logic                w_make_ev;
    logic [NUM_CMDS-1:0] w_key;
    logic [NUM_CMDS-1:0] w_make_hit;
    logic [NUM_CMDS-1:0] w_brk_hit;
    logic [NUM_CMDS-1:0] w_new;
    logic [NUM_CMDS-1:0] w_rep;

    always_comb begin
        w_ext     = (r_state == S_EXT) || (r_state == S_EXT_BRK);
        w_key     = key_onehot(i_scan_code, w_ext);
        w_brk_ev  = i_scan_valid && ((r_state == S_BRK) || (r_state == S_EXT_BRK));
        w_make_ev = i_scan_valid &&
                    (((r_state == S_IDLE) && (i_scan_code != SC_BREAK) && (i_scan_code != SC_EXT)) ||
                     ((r_state == S_EXT)  && (i_scan_code != SC_BREAK)));
        w_make_hit = w_make_ev ? w_key : '0;
        w_brk_hit  = w_brk_ev  ? w_key : '0;
        // Typematic repeats of an already-held key produce no pulse.
        w_new      = w_make_hit & ~r_held;
    end

`ifdef KEY_AUTOREPEAT_EN
    logic r_rep_right;
    logic w_rep_start;
    logic w_rep_cancel;
    logic w_fire;

    assign w_rep_start  = w_new[CMD_LEFT] | w_new[CMD_RIGHT];
    assign w_rep_cancel = r_rep_right ? w_brk_hit[CMD_RIGHT] : w_brk_hit[CMD_LEFT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_rep_right <= 1'b0;
        else if (w_rep_start)
            r_rep_right <= w_new[CMD_RIGHT];
    end

    key_repeat_timer #(
        .DELAY  (REPEAT_DELAY),
        .PERIOD (REPEAT_PERIOD)
    ) u_rep (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (w_rep_start),
        .i_cancel (w_rep_cancel),
        .o_fire   (w_fire)
    );

    always_comb begin
        w_rep = '0;
        if (w_fire) begin
            if (r_rep_right) w_rep[CMD_RIGHT] = 1'b1;
            else             w_rep[CMD_LEFT]  = 1'b1;
        end
    end
`else
    assign w_rep = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_tmo   <= '0;
            r_held  <= '0;
            r_pulse <= '0;
        end else begin
            r_pulse <= w_new | w_rep;
            r_held  <= (r_held | w_make_hit) & ~w_brk_hit;
            if (i_scan_valid) begin
                r_tmo <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (i_scan_code == SC_BREAK)    r_state <= S_BRK;
                        else if (i_scan_code == SC_EXT) r_state <= S_EXT;
                    end
                    S_EXT:   r_state <= (i_scan_code == SC_BREAK) ? S_EXT_BRK : S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state != S_IDLE) begin
                // A prefix with no follow-up byte is stale after PREFIX_TIMEOUT idle cycles.
                if (r_tmo == TW'(PREFIX_TIMEOUT - 1)) begin
                    r_state <= S_IDLE;
                    r_tmo   <= '0;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end else begin
                r_tmo <= '0;
            end
        end
    end

    assign o_left   = r_pulse[CMD_LEFT];
    assign o_right  = r_pulse[CMD_RIGHT];
    assign o_select = r_pulse[CMD_SELECT];
    assign o_start  = r_pulse[CMD_START];
    assign o_uno    = r_pulse[CMD_UNO];
    assign o_held   = r_held;

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Self-checking bench for ps2_cmd_decoder: directed test-plan sequences plus a
// randomized byte stream checked against a behavioural key model.
module tb_ps2_cmd_decoder;

    localparam int TMO = 4095;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld = 1'b0;
    logic [7:0] code = 8'h00;
    logic       o_left, o_right, o_select, o_start, o_uno;
    logic [4:0] o_held;
    logic [4:0] pulses;

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model: pending break/extended flags, held bits, idle gap.
    bit         m_brk, m_ext;
    logic [4:0] m_held;
    int         m_idle;

    ps2_cmd_decoder #(
        .PREFIX_TIMEOUT (TMO),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_scan_valid (vld),
        .i_scan_code  (code),
        .o_left       (o_left),
        .o_right      (o_right),
        .o_select     (o_select),
        .o_start      (o_start),
        .o_uno        (o_uno),
        .o_held       (o_held)
    );

    assign pulses = {o_uno, o_start, o_select, o_right, o_left};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int key_idx(input logic [7:0] c, input bit ext);
        if (ext) begin
            if (c == 8'h6B) return 0;
            if (c == 8'h74) return 1;
            if (c == 8'h5A) return 2;
            return -1;
        end
        if (c == 8'h15) return 0;
        if (c == 8'h24) return 1;
        if (c == 8'h5A) return 2;
        if (c == 8'h29) return 3;
        if (c == 8'h3C) return 4;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b, output logic [4:0] exp_p);
        int k;
        exp_p = '0;
        if (m_idle >= TMO) begin
            m_brk = 0;
            m_ext = 0;
        end
        if (m_brk) begin
            k = key_idx(b, m_ext);
            if (k >= 0) m_held[k] = 1'b0;
            m_brk = 0;
            m_ext = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (!m_ext && b == 8'hE0) begin
            m_ext = 1;
        end else begin
            k = key_idx(b, m_ext);
            if (k >= 0 && !m_held[k]) begin
                exp_p[k]  = 1'b1;
                m_held[k] = 1'b1;
            end
            m_ext = 0;
        end
        m_idle = 0;
    endtask

    // Called at a negedge; drives one byte for one cycle and checks the result.
    task automatic send(input logic [7:0] b, input string tag);
        logic [4:0] exp_p;
        model_byte(b, exp_p);
        code = b;
        vld  = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        chk({tag, "_pulse"}, 32'(pulses), 32'(exp_p));
        chk({tag, "_held"},  32'(o_held), 32'(m_held));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            m_idle++;
            chk("idle_pulse", 32'(pulses), 32'd0);
        end
    endtask

    task automatic do_reset();
        vld   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pulse", 32'(pulses), 32'd0);
        chk("rst_held",  32'(o_held), 32'd0);
        rst_n  = 1'b1;
        m_brk  = 0;
        m_ext  = 0;
        m_held = '0;
        m_idle = 0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] pool [10];
        pool = '{8'h15, 8'h24, 8'h5A, 8'h29, 8'h3C, 8'h6B, 8'h74, 8'hF0, 8'hE0, 8'h00};
        m_held = '0;

        do_reset();

        // Make / break of right
        send(8'h24, "right_make");
        idle(2);
        send(8'hF0, "f0");
        send(8'h24, "right_brk");
        idle(1);

        // Typematic select: one pulse, then a second after a break
        repeat (5) send(8'h5A, "sel_typematic");
        send(8'hF0, "f0");
        send(8'h5A, "sel_brk");
        send(8'h5A, "sel_remake");
        send(8'hF0, "f0");
        send(8'h5A, "sel_brk2");

        // Extended codes share held bits with their plain counterparts
        send(8'hE0, "e0");
        send(8'h6B, "ext_left_make");
        send(8'hE0, "e0");
        send(8'hF0, "ef0");
        send(8'h6B, "ext_left_brk");
        send(8'h5A, "sel_make");
        send(8'hE0, "e0");
        send(8'h5A, "ext_sel_held");
        send(8'hF0, "f0");
        send(8'h5A, "sel_brk3");

        // Stale break prefix times out; next byte is a make
        send(8'hF0, "f0_stale");
        idle(TMO + 1);
        send(8'h29, "start_after_tmo");
        send(8'hF0, "f0");
        send(8'h29, "start_brk");

        // Reset between F0 and 3C discards the prefix
        send(8'hF0, "f0_pre_rst");
        do_reset();
        send(8'h3C, "uno_after_rst");

`ifdef KEY_AUTOREPEAT_EN
        do_reset();
        send(8'h15, "rep_make");
        for (int k = 2; k <= 24; k++) begin
            @(negedge clk);
            chk("rep_left", 32'(o_left), 32'((k == 11 || k == 15 || k == 19 || k == 23) ? 1 : 0));
        end
        send(8'hF0, "rep_f0");
        send(8'h15, "rep_brk");
        idle(20);
`else
        // Randomized stream, back-to-back and gapped bytes
        for (int i = 0; i < 400; i++) begin
            logic [7:0] b;
            b = pool[$urandom_range(0, 9)];
            if (b == 8'h00) b = 8'($urandom);
            send(b, "rand");
            idle($urandom_range(0, 2));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
